mac_requant: RTL and testbench
==============================

Name: mac_requant

Overview:
- Requantization back-end for the MAC: takes packed int accumulator results (the 24-bit intr word) and converts them into packed low-precision operand words in the same lane format as the MAC's value/weight inputs.
- Scales each lane, rounds, shifts and saturates it, then packs the lanes into a 16-bit word, so results can be written back as next-layer activations.
- Two-stage valid/ready pipeline with a saturation event counter.

Parameters:
- ACC_W, 24, accumulator word width; fixed by the MAC intr port.
- OUT_W, 16, packed output word width; matches the MAC value port.
- SCALE_W, 8, unsigned scale width.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  accumulator beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_mode  in  4  one-hot mode: bit0 fp, bit1 int_s, bit2 int_m, bit3 int_l.
- in_acc  in  24  packed signed accumulator lanes.
- cfg_scale  in  8  unsigned multiplier; sampled with each accepted beat.
- cfg_shift  in  5  arithmetic right shift, 0..31; sampled with each accepted beat.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  packed signed result lanes.
- out_mode  out  4  mode of the beat, carried through the pipeline.
- err  out  1  one-cycle pulse when a beat is dropped.
- sat_cnt  out  16  count of saturated lanes.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Lane packing: lane 0 is at the LSBs.
  - int_s: input is 4 lanes of 6 bits; output is 4 lanes of 4 bits.
  - int_m: input is 2 lanes of 12 bits; output is 2 lanes of 8 bits.
  - int_l: input is 1 lane of 24 bits; output is 1 lane of 16 bits.
- Arithmetic, per lane:
  - Sign-extend the lane, then p = lane * {0,scale}, computed as a 34-bit signed value.
  - If shift>0, add 1<<(shift-1) (round half up); if shift=0, add nothing.
  - y = sum >>> shift, arithmetic shift.
  - Saturate y to the signed output lane range, e.g. int_m clamps to [-128,127].
  - Each clamped lane counts as one saturation event.
- Pipeline:
  - S1 captures the beat, mode, cfg and the products.
  - S2 holds the rounded, shifted, saturated and packed result, and drives out_data, out_mode and out_valid.
  - Latency is 2 cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is 1 beat per cycle.
- Handshake:
  - s2_adv = ~s2_v | out_ready.
  - s1_adv = ~s1_v | s2_adv.
  - in_ready = s1_adv.
  - A beat is accepted when in_valid & in_ready.
  - A transfer occurs when out_valid & out_ready.
  - out_data and out_mode stay stable while out_valid & ~out_ready.
- Invalid mode (fp, zero, or not one-hot):
  - The beat is accepted and dropped; no output is produced.
  - err pulses for one cycle, the cycle after acceptance.
  - sat_cnt is unchanged.
- sat_cnt:
  - Adds the number of saturated lanes (0..4) of a beat when that beat enters S2.
  - Saturates at 16'hFFFF; no wrap.
  - sat_clr has priority over an increment in the same cycle; the result is 0.
- Reset (rst_n low at a clock edge):
  - s1_v, s2_v, out_valid and err go to 0.
  - out_data and out_mode go to 0; sat_cnt goes to 0.
  - In-flight beats are discarded, including a reset mid-stall.
  - in_ready is 1 on the first cycle after reset is released.
- cfg changes only affect beats accepted afterwards; beats already in flight keep their sampled cfg.

Test Plan:
- int_l, in_acc=24'h000100, scale=1, shift=4 -> out_data=16'h0010 two cycles after acceptance, sat_cnt unchanged.
- int_m, in_acc=24'h7FF801, scale=2, shift=3 -> out_data=16'h7F80 (+127 and -128 clamps), sat_cnt increments by 2.
- int_s, in_acc=24'h17D01F (lanes 5,-3,0,31), scale=1, shift=1 -> out_data=16'h3F07, sat_cnt increments by 1.
- out_ready=0, 3 consecutive int_l beats -> 2 beats accepted, then in_ready=0. Raise out_ready -> 3 results delivered in order with no duplicates or loss. An fp-mode beat -> err pulse and no out_valid.
- Reset mid-operation: S1 and S2 full under stall, rst_n low for one cycle -> out_valid=0 and sat_cnt=0 next cycle, in_ready=1.
- sat_cnt preset to 16'hFFFE, then a beat with 4 saturated lanes -> sat_cnt=16'hFFFF. sat_clr asserted in the same cycle as an increment -> sat_cnt=0.

Source files
------------

// File: rtl/mac_requant.sv
// Requantization back-end for the MAC: scales, rounds, shifts and saturates
// packed accumulator lanes into packed low-precision operand words.
module mac_requant #(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int SCALE_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_mode,
  input  logic [ACC_W-1:0]   in_acc,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [4:0]         cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [3:0]         out_mode,
  output logic               err,
  output logic [CNT_W-1:0]   sat_cnt,
  input  logic               sat_clr
);

  localparam int PW   = 34;
  localparam int SW   = ACC_W / 4;
  localparam int MW   = ACC_W / 2;
  localparam int OW_S = OUT_W / 4;
  localparam int OW_M = OUT_W / 2;

  localparam logic signed [PW-1:0] HI_S = PW'(2**(OW_S-1) - 1);
  localparam logic signed [PW-1:0] LO_S = -PW'(2**(OW_S-1));
  localparam logic signed [PW-1:0] HI_M = PW'(2**(OW_M-1) - 1);
  localparam logic signed [PW-1:0] LO_M = -PW'(2**(OW_M-1));
  localparam logic signed [PW-1:0] HI_L = PW'(2**(OUT_W-1) - 1);
  localparam logic signed [PW-1:0] LO_L = -PW'(2**(OUT_W-1));

  localparam logic [OUT_W-1:0] LM_S = OUT_W'(2**OW_S - 1);
  localparam logic [OUT_W-1:0] LM_M = OUT_W'(2**OW_M - 1);

  typedef enum logic [1:0] {FMT_S, FMT_M, FMT_L, FMT_BAD} fmt_e;

  // Handshake
  logic s1_v, s2_v, s1_adv, s2_adv, accept;

  assign s2_adv    = ~s2_v | out_ready;
  assign s1_adv    = ~s1_v | s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_v;

  // Input decode and lane products
  fmt_e                  in_fmt;
  logic signed [PW-1:0]  lane    [4];
  logic signed [PW-1:0]  prod    [4];
  logic signed [PW-1:0]  scale_x;

  always_comb begin
    case (in_mode)
      4'b0010: in_fmt = FMT_S;
      4'b0100: in_fmt = FMT_M;
      4'b1000: in_fmt = FMT_L;
      default: in_fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    scale_x = $signed({{(PW-SCALE_W){1'b0}}, cfg_scale});
    for (int unsigned i = 0; i < 4; i++) lane[i] = '0;
    case (in_fmt)
      FMT_S: begin
        for (int unsigned i = 0; i < 4; i++)
          lane[i] = {{(PW-SW){in_acc[SW*i+SW-1]}}, in_acc[SW*i +: SW]};
      end
      FMT_M: begin
        lane[0] = {{(PW-MW){in_acc[MW-1]}}, in_acc[MW-1:0]};
        lane[1] = {{(PW-MW){in_acc[ACC_W-1]}}, in_acc[ACC_W-1:MW]};
      end
      FMT_L: lane[0] = {{(PW-ACC_W){in_acc[ACC_W-1]}}, in_acc};
      default: ;
    endcase
    for (int unsigned i = 0; i < 4; i++) prod[i] = lane[i] * scale_x;
  end

  // Stage 1 registers
  fmt_e                  s1_fmt;
  logic [3:0]            s1_mode;
  logic [4:0]            s1_shift;
  logic signed [PW-1:0]  s1_p [4];

  // Stage 2 combinational: round, shift, clamp, pack
  logic signed [PW-1:0]  rnd, hi, lo;
  logic signed [PW-1:0]  sum [4];
  logic signed [PW-1:0]  y   [4];
  logic [OUT_W-1:0]      v   [4];
  logic [3:0]            f;
  logic [OUT_W-1:0]      s2_data;
  logic [2:0]            nsat;
  logic [CNT_W:0]        cnt_sum;
  logic [CNT_W-1:0]      cnt_next;

  always_comb begin
    rnd = '0;
    if (s1_shift != 5'd0) rnd = {{(PW-1){1'b0}}, 1'b1} << (s1_shift - 5'd1);
    case (s1_fmt)
      FMT_S:   begin hi = HI_S; lo = LO_S; end
      FMT_M:   begin hi = HI_M; lo = LO_M; end
      default: begin hi = HI_L; lo = LO_L; end
    endcase
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i] = s1_p[i] + rnd;
      y[i]   = sum[i] >>> s1_shift;
      f[i]   = 1'b0;
      if (y[i] > hi) begin
        v[i] = hi[OUT_W-1:0];
        f[i] = 1'b1;
      end else if (y[i] < lo) begin
        v[i] = lo[OUT_W-1:0];
        f[i] = 1'b1;
      end else begin
        v[i] = y[i][OUT_W-1:0];
      end
    end
  end

  // Only lanes that exist in the beat's format are packed and counted
  always_comb begin
    case (s1_fmt)
      FMT_S: begin
        s2_data = (v[0] & LM_S) | ((v[1] & LM_S) << OW_S) |
                  ((v[2] & LM_S) << (2*OW_S)) | ((v[3] & LM_S) << (3*OW_S));
        nsat = {2'b0, f[0]} + {2'b0, f[1]} + {2'b0, f[2]} + {2'b0, f[3]};
      end
      FMT_M: begin
        s2_data = (v[0] & LM_M) | ((v[1] & LM_M) << OW_M);
        nsat    = {2'b0, f[0]} + {2'b0, f[1]};
      end
      default: begin
        s2_data = v[0];
        nsat    = {2'b0, f[0]};
      end
    endcase
    cnt_sum  = {1'b0, sat_cnt} + {{(CNT_W-2){1'b0}}, nsat};
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      err      <= 1'b0;
      s1_fmt   <= FMT_BAD;
      s1_mode  <= '0;
      s1_shift <= '0;
      for (int unsigned i = 0; i < 4; i++) s1_p[i] <= '0;
      out_data <= '0;
      out_mode <= '0;
      sat_cnt  <= '0;
    end else begin
      err <= accept & (in_fmt == FMT_BAD);
      if (s1_adv) begin
        s1_v <= accept & (in_fmt != FMT_BAD);
        if (accept) begin
          s1_fmt   <= in_fmt;
          s1_mode  <= in_mode;
          s1_shift <= cfg_shift;
          for (int unsigned i = 0; i < 4; i++) s1_p[i] <= prod[i];
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_data <= s2_data;
          out_mode <= s1_mode;
        end
      end
      if (sat_clr)
        sat_cnt <= '0;
      else if (s1_v && s2_adv)
        sat_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: hand-computed vectors, stalls, drops,
// reset mid-stall and saturation-counter limits.
module tb_mac_requant;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, err, sat_clr;
  logic [3:0]  in_mode, out_mode;
  logic [23:0] in_acc;
  logic [7:0]  cfg_scale;
  logic [4:0]  cfg_shift;
  logic [15:0] out_data, sat_cnt;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mac_requant #(.ACC_W(24), .OUT_W(16), .SCALE_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_acc(in_acc), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .err(err),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [23:0] a,
                      input logic [7:0] sc, input logic [4:0] sh);
    in_valid  = 1'b1;
    in_mode   = m;
    in_acc    = a;
    cfg_scale = sc;
    cfg_shift = sh;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    in_mode = 4'd0; in_acc = '0; cfg_scale = '0; cfg_shift = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_sat_cnt",   32'(sat_cnt),   32'h0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // int_l basic, latency 2
    send(4'b1000, 24'h000100, 8'd1, 5'd4);
    check("l_lat1_valid", 32'(out_valid), 32'd0);
    step();
    check("l_valid", 32'(out_valid), 32'd1);
    check("l_data",  32'(out_data),  32'h0010);
    check("l_mode",  32'(out_mode),  32'h8);
    check("l_sat",   32'(sat_cnt),   32'h0);

    // int_m, both lanes clamp
    send(4'b0100, 24'h7FF801, 8'd2, 5'd3);
    step();
    check("m_data", 32'(out_data), 32'h7F80);
    check("m_mode", 32'(out_mode), 32'h4);
    check("m_sat",  32'(sat_cnt),  32'h2);

    // int_s, lanes 5,-3,0,31
    send(4'b0010, 24'h17D01F, 8'd1, 5'd1);
    step();
    check("s_data", 32'(out_data), 32'h3F07);
    check("s_mode", 32'(out_mode), 32'h2);
    check("s_sat",  32'(sat_cnt),  32'h3);

    // int_l negative round half up: -24/16 = -1.5 -> -1
    send(4'b1000, 24'hFFFFE8, 8'd1, 5'd4);
    step();
    check("lneg_data", 32'(out_data), 32'hFFFF);
    check("lneg_sat",  32'(sat_cnt),  32'h3);

    // back-to-back beats with cfg change between them
    in_valid = 1'b1; in_mode = 4'b1000; in_acc = 24'h000010;
    cfg_scale = 8'd1; cfg_shift = 5'd0;
    step();
    cfg_scale = 8'd3;
    step();
    in_valid = 1'b0;
    check("b2b_first",  32'(out_data), 32'h0010);
    step();
    check("b2b_second", 32'(out_data), 32'h0030);
    check("b2b_valid",  32'(out_valid), 32'd1);
    step();
    check("b2b_idle",   32'(out_valid), 32'd0);

    // backpressure: 3 beats, out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 4'b1000; in_acc = 24'd1;
    cfg_scale = 8'd1; cfg_shift = 5'd0;
    #1;
    check("bp_rdy0", 32'(in_ready), 32'd1);
    step();
    in_acc = 24'd2;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    in_acc = 24'd3;
    check("bp_rdy2",   32'(in_ready),  32'd0);
    check("bp_valid",  32'(out_valid), 32'd1);
    check("bp_data_a", 32'(out_data),  32'h0001);
    step();
    check("bp_hold_data", 32'(out_data), 32'h0001);
    check("bp_hold_mode", 32'(out_mode), 32'h8);
    check("bp_hold_rdy",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_data_b", 32'(out_data), 32'h0002);
    step();
    check("bp_data_c", 32'(out_data), 32'h0003);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // invalid modes dropped with err pulse
    send(4'b0001, 24'h7DF7DF, 8'd255, 5'd0);
    check("fp_err",   32'(err),       32'd1);
    check("fp_valid", 32'(out_valid), 32'd0);
    step();
    check("fp_err_off", 32'(err),       32'd0);
    check("fp_noout",   32'(out_valid), 32'd0);
    check("fp_sat",     32'(sat_cnt),   32'h3);
    send(4'b0110, 24'h7DF7DF, 8'd255, 5'd0);
    check("multi_err", 32'(err), 32'd1);
    step();
    check("multi_noout", 32'(out_valid), 32'd0);

    // reset with both stages full under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 4'b1000; in_acc = 24'd5; cfg_scale = 8'd1; cfg_shift = 5'd0;
    step();
    in_acc = 24'd6;
    step();
    in_valid = 1'b0;
    check("mid_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_sat",   32'(sat_cnt),   32'h0);
    check("mid_data",  32'(out_data),  32'h0);
    check("mid_rdy",   32'(in_ready),  32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_ghost1", 32'(out_valid), 32'd0);
    step();
    check("mid_ghost2", 32'(out_valid), 32'd0);

    // drive sat_cnt to FFFC with 16383 four-lane saturating beats
    in_valid = 1'b1; in_mode = 4'b0010; in_acc = 24'h7DF7DF;
    cfg_scale = 8'd255; cfg_shift = 5'd0;
    repeat (16383) step();
    in_valid = 1'b0;
    step();
    check("sat4_data", 32'(out_data), 32'h7777);
    step();
    check("cnt_fffc", 32'(sat_cnt), 32'hFFFC);
    send(4'b0100, 24'h7FF801, 8'd2, 5'd3);
    step();
    check("cnt_fffe", 32'(sat_cnt), 32'hFFFE);
    send(4'b0010, 24'h7DF7DF, 8'd255, 5'd0);
    step();
    check("cnt_clamp", 32'(sat_cnt), 32'hFFFF);

    // clear wins over increment
    send(4'b0010, 24'h7DF7DF, 8'd255, 5'd0);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("cnt_clr", 32'(sat_cnt), 32'h0);
    send(4'b0010, 24'h7DF7DF, 8'd255, 5'd0);
    step();
    check("cnt_after_clr", 32'(sat_cnt), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
